// File: rtl/parser_wait_segs.sv
// ============================================================================
// parser_wait_segs : gathers the first C_NUM_SEGS beats of each AXIS packet
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module parser_wait_segs #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                                    s_axis_tvalid,
  input  logic                                    s_axis_tready,
  input  logic                                    s_axis_tlast,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
  output logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st,
  output logic                                    segs_valid
);

  localparam int W      = C_AXIS_DATA_WIDTH;
  localparam int SEGS_W = C_NUM_SEGS * W;
  localparam int CNT_W  = $clog2(C_NUM_SEGS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_EOP = 2'd2
  } state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic [SEGS_W-1:0]              seg_buf, seg_buf_nxt;
  logic [C_AXIS_TUSER_WIDTH-1:0]  user_buf, user_nxt;
  logic                           accept;
  logic                           emit;

  assign accept = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    seg_buf_nxt = seg_buf;
    user_nxt    = user_buf;
    emit        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          // Clearing the upper segments here keeps short packets zero-padded.
          seg_buf_nxt        = '0;
          seg_buf_nxt[W-1:0] = s_axis_tdata;
          user_nxt           = s_axis_tuser;
          cnt_nxt            = CNT_W'(1);
          if (s_axis_tlast || (C_NUM_SEGS == 1)) begin
            emit      = 1'b1;
            state_nxt = s_axis_tlast ? IDLE : WAIT_EOP;
          end else begin
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          for (int i = 0; i < C_NUM_SEGS; i++) begin
            if (cnt == CNT_W'(i)) begin
              seg_buf_nxt[i*W +: W] = s_axis_tdata;
            end
          end
          cnt_nxt = cnt + CNT_W'(1);
          if (s_axis_tlast || (cnt_nxt == CNT_W'(C_NUM_SEGS))) begin
            emit      = 1'b1;
            state_nxt = s_axis_tlast ? IDLE : WAIT_EOP;
          end
        end
      end
      WAIT_EOP: begin
        if (accept && s_axis_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      seg_buf    <= '0;
      user_buf   <= '0;
      segs_valid <= 1'b0;
      tdata_segs <= '0;
      tuser_1st  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      seg_buf    <= seg_buf_nxt;
      user_buf   <= user_nxt;
      segs_valid <= emit;
      if (emit) begin
        tdata_segs <= seg_buf_nxt;
        tuser_1st  <= user_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parser_wait_segs.sv
// ============================================================================
// tb_parser_wait_segs : scoreboard bench for parser_wait_segs (2-seg and 1-seg)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parser_wait_segs;

  localparam int W  = 64;
  localparam int TU = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    tdata;
  logic [TU-1:0]   tuser;
  logic            tvalid, tready, tlast;
  logic [2*W-1:0]  segs2;
  logic [TU-1:0]   user2;
  logic            valid2;
  logic [W-1:0]    segs1;
  logic [TU-1:0]   user1;
  logic            valid1;

  parser_wait_segs #(.C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(TU), .C_NUM_SEGS(2)) dut2 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .tdata_segs(segs2), .tuser_1st(user2), .segs_valid(valid2)
  );

  parser_wait_segs #(.C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(TU), .C_NUM_SEGS(1)) dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .tdata_segs(segs1), .tuser_1st(user1), .segs_valid(valid1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] segs;
    logic [TU-1:0]  user;
    int             at;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   last_cyc = 0;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse arrives one cycle after the accepting edge of the emitting beat.
  task automatic beat(input logic [W-1:0] d, input logic [TU-1:0] u, input logic l, input int stall = 0);
    @(posedge clk); #1;
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
    tready = (stall == 0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
    end
    tready   = 1'b1;
    last_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      tvalid = 1'b0; tlast = 1'b0;
    end
  endtask

  task automatic exp2(input logic [2*W-1:0] s, input logic [TU-1:0] u);
    exp_t e;
    e.segs = s; e.user = u; e.at = last_cyc;
    q2.push_back(e);
  endtask

  task automatic exp1(input logic [W-1:0] s, input logic [TU-1:0] u);
    exp_t e;
    e.segs = {{W{1'b0}}, s}; e.user = u; e.at = last_cyc;
    q1.push_back(e);
  endtask

  exp_t m2, m1;
  always @(negedge clk) begin
    if (valid2 === 1'b1) begin
      if (q2.size() == 0) check("dut2_unexpected_pulse", 1, 0);
      else begin
        m2 = q2.pop_front();
        check("dut2_segs", segs2, m2.segs);
        check("dut2_tuser", {{(2*W-TU){1'b0}}, user2}, {{(2*W-TU){1'b0}}, m2.user});
        check("dut2_latency", cyc, m2.at);
      end
    end
    if (valid1 === 1'b1) begin
      if (q1.size() == 0) check("dut1_unexpected_pulse", 1, 0);
      else begin
        m1 = q1.pop_front();
        check("dut1_segs", {{W{1'b0}}, segs1}, m1.segs);
        check("dut1_tuser", {{(2*W-TU){1'b0}}, user1}, {{(2*W-TU){1'b0}}, m1.user});
        check("dut1_latency", cyc, m1.at);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_valid2"}, valid2, 0);
    check({tag, "_segs2"}, segs2, 0);
    check({tag, "_user2"}, user2, 0);
    check({tag, "_valid1"}, valid1, 0);
    check({tag, "_segs1"}, segs1, 0);
    check({tag, "_user1"}, user1, 0);
  endtask

  logic [W-1:0]  rd, d0;
  logic [TU-1:0] ru, u0;
  int            len;

  initial begin
    rst = 1'b1; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0; tdata = '0; tuser = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    // 4-beat packet: pulse after B only
    beat(64'hA0A0, 16'h1111, 0); exp1(64'hA0A0, 16'h1111);
    beat(64'hB0B0, 16'h2222, 0); exp2({64'hB0B0, 64'hA0A0}, 16'h1111);
    beat(64'hC0C0, 16'h3333, 0);
    beat(64'hD0D0, 16'h4444, 1);
    idle(3);

    // single-beat packet, then a 2-beat packet proves it stayed in IDLE
    beat(64'hA1, 16'h0101, 1); exp1(64'hA1, 16'h0101); exp2({64'h0, 64'hA1}, 16'h0101);
    beat(64'hE1, 16'h0E0E, 0); exp1(64'hE1, 16'h0E0E);
    beat(64'hF1, 16'h0F0F, 1); exp2({64'hF1, 64'hE1}, 16'h0E0E);
    idle(2);

    // back-to-back 2-beat packets
    beat(64'h1111_0001, 16'h00A1, 0); exp1(64'h1111_0001, 16'h00A1);
    beat(64'h1111_0002, 16'h00A2, 1); exp2({64'h1111_0002, 64'h1111_0001}, 16'h00A1);
    beat(64'h2222_0001, 16'h00B1, 0); exp1(64'h2222_0001, 16'h00B1);
    beat(64'h2222_0002, 16'h00B2, 1); exp2({64'h2222_0002, 64'h2222_0001}, 16'h00B1);
    idle(2);

    // tready stall for 3 cycles on beat B
    beat(64'h5A5A, 16'h5555, 0); exp1(64'h5A5A, 16'h5555);
    beat(64'h5B5B, 16'h6666, 1, 3); exp2({64'h5B5B, 64'h5A5A}, 16'h5555);
    idle(3);

    // reset after beat A of a 3-beat packet
    beat(64'h7A, 16'h7001, 0); exp1(64'h7A, 16'h7001);
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("midreset");
    beat(64'h7B, 16'h7002, 0); exp1(64'h7B, 16'h7002);
    beat(64'h7C, 16'h7003, 1); exp2({64'h7C, 64'h7B}, 16'h7002);
    idle(3);

    // random back-to-back packets of length 1..4
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        rd = {$urandom, $urandom};
        ru = 16'($urandom);
        if (b == 0) begin d0 = rd; u0 = ru; end
        beat(rd, ru, b == len - 1);
        if (b == 0) exp1(rd, ru);
        if (b == 0 && len == 1) exp2({64'h0, rd}, ru);
        if (b == 1) exp2({rd, d0}, u0);
      end
    end
    idle(5);

    check("dut2_missing_pulses", q2.size(), 0);
    check("dut1_missing_pulses", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
